pc_unit_ras: RTL

Fetch-side program-counter unit for the pipelined MIPS core. It owns the PC_F register and resolves every control transfer in D: j, jal, jr, jalr, beq, bne, blez, bgtz, bltz and bgez. It also handles exception and eret redirects. A parametrised return-address stack (RAS) and performance counters are included for jr $31 prediction checking.

---
 rtl/mips_defs.sv | 45 ++++
 rtl/pc_unit_ras_if.sv | 42 ++++
 rtl/ras_stack.sv | 66 ++++++
 rtl/pc_unit_ras.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// ==========================================================================
// mips_defs : MIPS opcode/funct encodings and fetch-unit defaults.
// Rev 1.0
// ==========================================================================
`default_nettype none

package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] REG_RA     = 5'd31;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef struct packed {
    logic is_branch;
    logic cond;
    logic jump_imm;
    logic jump_reg;
  } cf_t;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_unit_ras_if.sv
// ==========================================================================
// pc_unit_ras_if : decode-side inputs and fetch/RAS/counter outputs.
// Rev 1.0
// ==========================================================================
`default_nettype none

interface pc_unit_ras_if #(
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = 16
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic [31:0]       IR_D;
  logic [31:0]       PC4_D;
  logic [31:0]       RS_D;
  logic [31:0]       RT_D;
  logic              exc_req;
  logic              eret;
  logic [31:0]       epc;

  logic [31:0]       PC_F;
  logic [31:0]       PC4_F;
  logic              flush_f;
  logic [31:0]       ras_top;
  logic [CW-1:0]     ras_cnt;
  logic              ras_miss;
  logic [CNT_W-1:0]  br_taken_cnt;
  logic [CNT_W-1:0]  ras_miss_cnt;

  modport master (
    output stall, IR_D, PC4_D, RS_D, RT_D, exc_req, eret, epc,
    input  PC_F, PC4_F, flush_f, ras_top, ras_cnt, ras_miss, br_taken_cnt, ras_miss_cnt
  );

  modport slave (
    input  stall, IR_D, PC4_D, RS_D, RT_D, exc_req, eret, epc,
    output PC_F, PC4_F, flush_f, ras_top, ras_cnt, ras_miss, br_taken_cnt, ras_miss_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ras_stack.sv
// ==========================================================================
// ras_stack : circular return-address stack, oldest entry lost on overflow.
// Rev 1.0
// ==========================================================================
`default_nettype none

module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] w_top_idx;
  logic          w_empty, w_full, w_pop_ok;

  // ptr_q is the next free slot; when full it also marks the oldest entry
  assign w_top_idx = ptr_q - PW'(1);
  assign w_empty   = (cnt_q == '0);
  assign w_full    = (cnt_q == CW'(DEPTH));
  assign w_pop_ok  = pop && !w_empty;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (w_pop_ok && !push) begin
      ptr_d = w_top_idx;
      cnt_d = cnt_q - CW'(1);
    end else if (push && !w_pop_ok) begin
      ptr_d = ptr_q + PW'(1);
      if (!w_full) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Pop+push rewrites the current top in place
  always_ff @(posedge clk) begin
    if (push) mem_q[w_pop_ok ? w_top_idx : ptr_q] <= din;
  end

  assign top = w_empty ? '0 : mem_q[w_top_idx];
  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pc_unit_ras.sv
// ==========================================================================
// pc_unit_ras : fetch PC register, D-stage control-transfer resolution,
//               jr $31 return-address prediction check and perf counters.
// Rev 1.0
// ==========================================================================
`default_nettype none

module pc_unit_ras
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter int          RAS_DEPTH  = 8,
  parameter int          DELAY_SLOT = 1,
  parameter int          CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  pc_unit_ras_if.slave    pc_if
);
  localparam int          CW       = $clog2(RAS_DEPTH) + 1;
  localparam logic [31:0] LINK_OFF = (DELAY_SLOT != 0) ? 32'd4 : 32'd0;

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic        w_rs_neg, w_rs_zero;
  cf_t         w_cf;
  logic        w_redirect, w_accept, w_push, w_pop, w_miss_d, w_br_inc;
  logic [31:0] w_target, w_link, w_ras_top;
  logic [CW-1:0] w_ras_cnt;
  logic        w_unused;

  logic [31:0]      pc_q, pc_d;
  logic             miss_q;
  logic [CNT_W-1:0] br_cnt_q, miss_cnt_q;

  assign w_op      = pc_if.IR_D[31:26];
  assign w_rs      = pc_if.IR_D[25:21];
  assign w_rt      = pc_if.IR_D[20:16];
  assign w_rd      = pc_if.IR_D[15:11];
  assign w_fn      = pc_if.IR_D[5:0];
  assign w_unused  = ^pc_if.IR_D[10:6];
  assign w_rs_neg  = pc_if.RS_D[31];
  assign w_rs_zero = (pc_if.RS_D == 32'd0);

  always_comb begin
    w_cf = '0;
    case (w_op)
      OP_BEQ:     begin w_cf.is_branch = 1'b1; w_cf.cond = (pc_if.RS_D == pc_if.RT_D); end
      OP_BNE:     begin w_cf.is_branch = 1'b1; w_cf.cond = (pc_if.RS_D != pc_if.RT_D); end
      OP_BLEZ:    begin w_cf.is_branch = 1'b1; w_cf.cond = w_rs_neg || w_rs_zero; end
      OP_BGTZ:    begin w_cf.is_branch = 1'b1; w_cf.cond = !w_rs_neg && !w_rs_zero; end
      OP_REGIMM: begin
        w_cf.is_branch = (w_rt == RT_BLTZ) || (w_rt == RT_BGEZ);
        w_cf.cond      = (w_rt == RT_BLTZ) ? w_rs_neg : !w_rs_neg;
      end
      OP_J, OP_JAL: w_cf.jump_imm = 1'b1;
      OP_SPECIAL:   w_cf.jump_reg = (w_fn == FN_JR) || (w_fn == FN_JALR);
      default: ;
    endcase
  end

  assign w_redirect = (w_cf.is_branch && w_cf.cond) || w_cf.jump_imm || w_cf.jump_reg;
  assign w_target   = w_cf.jump_reg ? pc_if.RS_D :
                      w_cf.jump_imm ? jump_target(pc_if.PC4_D, pc_if.IR_D[25:0]) :
                                      branch_target(pc_if.PC4_D, pc_if.IR_D[15:0]);

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (pc_if.exc_req)                    pc_d = EXC_VEC;
    else if (pc_if.eret && !pc_if.stall)  pc_d = pc_if.epc;
    else if (pc_if.stall)                 pc_d = pc_q;
    else if (w_redirect)                  pc_d = w_target;
  end

  // RAS and counters only see instructions that actually leave D
  assign w_accept = !pc_if.stall && !pc_if.exc_req;
  assign w_push   = w_accept && ((w_op == OP_JAL) ||
                    ((w_op == OP_SPECIAL) && (w_fn == FN_JALR) && (w_rd == REG_RA)));
  assign w_pop    = w_accept && w_cf.jump_reg && (w_rs == REG_RA);
  assign w_link   = pc_if.PC4_D + LINK_OFF;
  assign w_miss_d = w_pop && (w_ras_cnt != '0) && (w_ras_top != pc_if.RS_D);
  assign w_br_inc = w_accept && w_cf.is_branch && w_cf.cond;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (32)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_link),
    .top   (w_ras_top),
    .cnt   (w_ras_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      miss_q     <= 1'b0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      miss_q <= w_miss_d;
      if (w_br_inc && (br_cnt_q != '1))   br_cnt_q   <= br_cnt_q + CNT_W'(1);
      if (w_miss_d && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  generate
    if (DELAY_SLOT == 0) begin : g_flush
      assign pc_if.flush_f = pc_if.exc_req || (!pc_if.stall && (pc_if.eret || w_redirect));
    end else begin : g_no_flush
      assign pc_if.flush_f = 1'b0;
    end
  endgenerate

  assign pc_if.PC_F         = pc_q;
  assign pc_if.PC4_F        = pc_q + 32'd4;
  assign pc_if.ras_top      = w_ras_top;
  assign pc_if.ras_cnt      = w_ras_cnt;
  assign pc_if.ras_miss     = miss_q;
  assign pc_if.br_taken_cnt = br_cnt_q;
  assign pc_if.ras_miss_cnt = miss_cnt_q;

endmodule

`default_nettype wire
